poly_midi_player: RTL and testbench

Polyphonic MIDI front end and mixer for the sound-test design. It parses a raw MIDI byte stream into note events and assigns them to NUM_VOICES voices using running status, per-voice gates and deterministic voice stealing. It also sums the voices' sample outputs into one saturated output stream. It sits between the MIDI byte receiver and the codec/PWM sample sink, with one external voice instance per channel.

---
 rtl/poly_midi_player.sv | 140 ++++++++++++++
 tb/tb_poly_midi_player.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/poly_midi_player.sv
// poly_midi_player: MIDI note parser with polyphonic voice allocation/stealing
// and a saturating sample mixer across all voices.
module poly_midi_player #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 16,
   parameter int MIDI_CH    = 0,
   parameter int OMNI       = 0
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [7:0]                     midi_data,
   input  logic                           midi_valid,
   output logic [7*NUM_VOICES-1:0]        voice_note,
   output logic [7*NUM_VOICES-1:0]        voice_vel,
   output logic [NUM_VOICES-1:0]          voice_gate,
   output logic [NUM_VOICES-1:0]          voice_trig,
   input  logic [SAMPLE_W*NUM_VOICES-1:0] voice_sample,
   input  logic                           sample_valid,
   output logic [SAMPLE_W-1:0]            sound_data,
   output logic                           sound_valid,
   output logic [4:0]                     active_count
);
   localparam int PW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} state_t;

   state_t state_q, state_d;
   logic on_q, on_d, ev, ev_on, ch_ok;
   logic [6:0] note_q, note_d;
   logic [NUM_VOICES-1:0][6:0] vnote_q, vnote_d, vvel_q, vvel_d;
   logic [NUM_VOICES-1:0] gate_q, gate_d, trig_q, trig_d;
   logic [PW-1:0] ptr_q, ptr_d, hit_i, free_i, sel;
   logic hit_f, free_f;
   logic [4:0] cnt_q, cnt_d;
   logic signed [SAMPLE_W+3:0] sum;
   logic [SAMPLE_W-1:0] mix_q, mix_d;
   logic mv_q;

   always_comb begin
      state_d = state_q;
      on_d    = on_q;
      note_d  = note_q;
      ev      = 1'b0;
      ev_on   = on_q && (midi_data[6:0] != 7'd0);
      ch_ok   = (OMNI != 0) || (midi_data[3:0] == 4'(MIDI_CH));
      // realtime bytes (F8..FF) pass through without touching the parser
      if (midi_valid && !(&midi_data[7:3])) begin
         if (midi_data[7:4] == 4'hF) state_d = IDLE;
         else if (midi_data[7]) begin
            on_d    = midi_data[4];
            state_d = (midi_data[6:5] == 2'b00 && ch_ok) ? WAIT_D1 : SKIP;
         end else if (state_q == WAIT_D1) begin
            note_d  = midi_data[6:0];
            state_d = WAIT_D2;
         end else if (state_q == WAIT_D2) begin
            ev      = 1'b1;
            state_d = WAIT_D1;
         end
      end
   end

   always_comb begin
      vnote_d = vnote_q;
      vvel_d  = vvel_q;
      gate_d  = gate_q;
      trig_d  = '0;
      ptr_d   = ptr_q;
      hit_f   = 1'b0;
      free_f  = 1'b0;
      hit_i   = '0;
      free_i  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!hit_f && gate_q[i] && vnote_q[i] == note_q) begin
            hit_f = 1'b1;
            hit_i = PW'(i);
         end
         if (!free_f && !gate_q[i]) begin
            free_f = 1'b1;
            free_i = PW'(i);
         end
      end
      sel = hit_f ? hit_i : free_f ? free_i : ptr_q;
      if (ev && ev_on) begin
         vnote_d[sel] = note_q;
         vvel_d[sel]  = midi_data[6:0];
         gate_d[sel]  = 1'b1;
         trig_d[sel]  = 1'b1;
         if (!hit_f && !free_f) ptr_d = (ptr_q == PW'(NUM_VOICES - 1)) ? '0 : ptr_q + 1'b1;
      end else if (ev) begin
         for (int i = 0; i < NUM_VOICES; i++)
            if (gate_q[i] && vnote_q[i] == note_q) gate_d[i] = 1'b0;
      end
      cnt_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) cnt_d = cnt_d + 5'(gate_q[i]);
   end

   // four guard bits cover the sum of up to 16 full-scale voices
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         sum = sum + {{4{voice_sample[SAMPLE_W*i+SAMPLE_W-1]}}, voice_sample[SAMPLE_W*i +: SAMPLE_W]};
      mix_d = (sum[SAMPLE_W+3:SAMPLE_W-1] == '0 || sum[SAMPLE_W+3:SAMPLE_W-1] == '1) ? sum[SAMPLE_W-1:0]
            : sum[SAMPLE_W+3] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         on_q    <= 1'b0;
         note_q  <= '0;
         vnote_q <= '0;
         vvel_q  <= '0;
         gate_q  <= '0;
         trig_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         mix_q   <= '0;
         mv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         on_q    <= on_d;
         note_q  <= note_d;
         vnote_q <= vnote_d;
         vvel_q  <= vvel_d;
         gate_q  <= gate_d;
         trig_q  <= trig_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         mv_q    <= sample_valid;
         if (sample_valid) mix_q <= mix_d;
      end
   end

   assign voice_note   = vnote_q;
   assign voice_vel    = vvel_q;
   assign voice_gate   = gate_q;
   assign voice_trig   = trig_q;
   assign sound_data   = mix_q;
   assign sound_valid  = mv_q;
   assign active_count = cnt_q;
endmodule

// File: tb/tb_poly_midi_player.sv
// tb_poly_midi_player: directed table plus hand sequences for the MIDI
// voice allocator and mixer with 4 voices on channel 0.
module tb_poly_midi_player;
   logic clk = 0, rst_n = 0, midi_valid = 0, sample_valid = 0;
   logic [7:0] midi_data = 0;
   logic [27:0] voice_note, voice_vel;
   logic [3:0] voice_gate, voice_trig;
   logic [63:0] voice_sample = 0;
   logic [15:0] sound_data;
   logic sound_valid;
   logic [4:0] active_count;
   int total = 0, bad = 0;
   logic [7:0] seq [16];

   typedef struct {
      logic [7:0]  b;
      bit          c;
      logic [3:0]  g;
      logic [27:0] n;
      logic [27:0] v;
      logic [4:0]  a;
   } rec_t;
   rec_t tbl[$];

   poly_midi_player dut (
      .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
      .voice_note(voice_note), .voice_vel(voice_vel), .voice_gate(voice_gate),
      .voice_trig(voice_trig), .voice_sample(voice_sample), .sample_valid(sample_valid),
      .sound_data(sound_data), .sound_valid(sound_valid), .active_count(active_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
      return {7'(d), 7'(c), 7'(b), 7'(a)};
   endfunction

   function automatic rec_t mk(input logic [7:0] b, input bit c, input logic [3:0] g,
                               input logic [27:0] n, input logic [27:0] v, input logic [4:0] a);
      rec_t r;
      r.b = b; r.c = c; r.g = g; r.n = n; r.v = v; r.a = a;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drives seq[0..n-1] on consecutive cycles; returns at the negedge after the last byte's edge
   task automatic burst(input int n);
      @(negedge clk);
      for (int k = 0; k < n; k++) begin
         midi_data = seq[k];
         midi_valid = 1;
         @(negedge clk);
      end
      midi_valid = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      logic [27:0] n1, v1, n2, v2;
      n1 = pk(60, 0, 0, 0);  v1 = pk(100, 0, 0, 0);
      n2 = pk(60, 64, 0, 0); v2 = pk(100, 80, 0, 0);
      tbl.push_back(mk(8'h90, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h3C, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h64, 1, 4'b0001, n1, v1, 1));
      tbl.push_back(mk(8'h40, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h50, 1, 4'b0011, n2, v2, 2));
      tbl.push_back(mk(8'h3C, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h00, 1, 4'b0010, n2, v2, 1));
      tbl.push_back(mk(8'h91, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h3C, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h64, 1, 4'b0010, n2, v2, 1));
      tbl.push_back(mk(8'hB0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h07, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h7F, 1, 4'b0010, n2, v2, 1));
      tbl.push_back(mk(8'h90, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'hF8, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h3D, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'hF8, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h30, 1, 4'b0011, pk(61, 64, 0, 0), pk(48, 80, 0, 0), 2));
      tbl.push_back(mk(8'hF0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h3E, 0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h7F, 1, 4'b0011, pk(61, 64, 0, 0), pk(48, 80, 0, 0), 2));

      #3;
      chk("rst_gate", voice_gate, 0);
      chk("rst_note", voice_note, 0);
      chk("rst_cnt", active_count, 0);
      chk("rst_sv", sound_valid, 0);
      do_reset();

      foreach (tbl[i]) begin
         seq[0] = tbl[i].b;
         burst(1);
         @(negedge clk);
         if (tbl[i].c) begin
            chk($sformatf("t%0d_gate", i), voice_gate, tbl[i].g);
            chk($sformatf("t%0d_note", i), voice_note, tbl[i].n);
            chk($sformatf("t%0d_vel", i), voice_vel, tbl[i].v);
            chk($sformatf("t%0d_cnt", i), active_count, tbl[i].a);
         end
      end

      // back-to-back stream filling all voices then stealing two
      do_reset();
      seq = '{8'h90, 8'h3C, 8'h64, 8'h3D, 8'h64, 8'h3E, 8'h64, 8'h3F, 8'h64,
              8'h40, 8'h64, 8'h41, 8'h64, 8'h00, 8'h00, 8'h00};
      burst(13);
      chk("steal_note", voice_note, pk(64, 65, 62, 63));
      chk("steal_gate", voice_gate, 4'b1111);
      chk("steal_trig", voice_trig, 4'b0010);
      @(negedge clk);
      chk("steal_cnt", active_count, 4);
      seq[0] = 8'h3F; seq[1] = 8'h01;
      burst(2);
      chk("retrig_trig", voice_trig, 4'b1000);
      chk("retrig_vel", voice_vel, pk(100, 100, 100, 1));
      chk("retrig_note", voice_note, pk(64, 65, 62, 63));
      @(negedge clk);
      chk("trig_pulse", voice_trig, 0);
      seq[0] = 8'h42; seq[1] = 8'h7F;
      burst(2);
      chk("steal3_note", voice_note, pk(64, 65, 66, 63));
      chk("steal3_trig", voice_trig, 4'b0100);

      // mixer
      voice_sample = {4{16'h7000}};
      sample_valid = 1;
      @(negedge clk);
      sample_valid = 0;
      chk("mix_pos_v", sound_valid, 1);
      chk("mix_pos", sound_data, 16'h7FFF);
      @(negedge clk);
      chk("mix_v_low", sound_valid, 0);
      voice_sample = {4{16'h9000}};
      sample_valid = 1;
      @(negedge clk);
      sample_valid = 0;
      chk("mix_neg", sound_data, 16'h8000);
      voice_sample = {16'h0000, 16'h0003, 16'hFFCE, 16'h0064};
      sample_valid = 1;
      @(negedge clk);
      sample_valid = 0;
      voice_sample = 0;
      chk("mix_sum", sound_data, 16'd53);
      @(negedge clk);
      chk("mix_hold", sound_data, 16'd53);
      chk("mix_hold_v", sound_valid, 0);

      // reset mid-message
      seq[0] = 8'h90; seq[1] = 8'h3C;
      burst(2);
      #2 rst_n = 0;
      #1;
      chk("arst_gate", voice_gate, 0);
      chk("arst_note", voice_note, 0);
      chk("arst_vel", voice_vel, 0);
      chk("arst_cnt", active_count, 0);
      chk("arst_snd", sound_data, 0);
      @(negedge clk);
      rst_n = 1;
      seq[0] = 8'h64;
      burst(1);
      @(negedge clk);
      chk("post_gate", voice_gate, 0);
      chk("post_trig", voice_trig, 0);
      seq = '{8'h90, 8'h3C, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      burst(3);
      chk("post_on_note", voice_note, pk(60, 0, 0, 0));
      chk("post_on_gate", voice_gate, 4'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
